// File: rtl/exec_step_controller.sv
// Run/halt/single-step sequencer producing one-cycle CPU clock-enable pulses on CLK100MHZ.
// Optional breakpoint matching is compiled in with `define BREAKPOINT_EN.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

module exec_step_controller #(
  parameter int unsigned DIV_WIDTH       = 21,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned PC_W            = `PC_SIZE
) (
  input  logic            CLK100MHZ,
  input  logic            RESETN,
  input  logic            run_sw,
  input  logic            step_btn,
  input  logic [1:0]      step_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic            cpu_halted,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_pc,
  output logic            cpu_ce,
  output logic [2:0]      state_out
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StStep   = 3'd2,
    StBreak  = 3'd3,
    StHalted = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic           cpu_ce_q, cpu_ce_d;
  logic           pulsed_once_q, pulsed_once_d;
  logic [DIV_WIDTH-1:0] div_q;
  logic           run_meta_q, run_sync_q;
  logic           btn_meta_q, btn_sync_q;
  logic [DbW-1:0] db_cnt_q;
  logic           db_level_q, db_prev_q;
  logic           tick, step_req, bp_hit, at_boundary;

  always_ff @(posedge CLK100MHZ or negedge RESETN) begin
    if (!RESETN) begin
      div_q      <= '0;
      run_meta_q <= 1'b0;
      run_sync_q <= 1'b0;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
    end else begin
      div_q      <= div_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      run_meta_q <= run_sw;
      run_sync_q <= run_meta_q;
      btn_meta_q <= step_btn;
      btn_sync_q <= btn_meta_q;
    end
  end

  // Counter runs only while the synchronised level disagrees with the accepted one, so any
  // bounce back to the accepted level restarts it.
  always_ff @(posedge CLK100MHZ or negedge RESETN) begin
    if (!RESETN) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
    end else begin
      db_prev_q <= db_level_q;
      if (btn_sync_q != db_level_q) begin
        if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
          db_level_q <= btn_sync_q;
          db_cnt_q   <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DbW'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  assign tick        = &div_q;
  assign at_boundary = (step_in == 2'd0);
  assign step_req    = db_level_q & ~db_prev_q & ((state_q == StIdle) || (state_q == StBreak));

`ifdef BREAKPOINT_EN
  assign bp_hit = bp_en & at_boundary & (pc_in == bp_pc);
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_pc, pc_in};
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cpu_ce_d      = 1'b0;
    pulsed_once_d = pulsed_once_q;
    unique case (state_q)
      StIdle: begin
        if (run_sync_q) begin
          state_d = StRun;
        end else if (step_req) begin
          state_d       = StStep;
          pulsed_once_d = 1'b0;
        end
      end
      StRun: begin
        if (tick) begin
          if (cpu_halted) begin
            state_d = StHalted;
          end else if (!run_sync_q && at_boundary) begin
            state_d = StIdle;
          end else if (bp_hit) begin
            state_d = StBreak;
          end else begin
            cpu_ce_d = 1'b1;
          end
        end
      end
      StStep: begin
        if (tick) begin
          if (cpu_halted) begin
            state_d = StHalted;
          end else if (pulsed_once_q && at_boundary) begin
            state_d = StIdle;
          end else begin
            cpu_ce_d      = 1'b1;
            pulsed_once_d = 1'b1;
          end
        end
      end
      StBreak: begin
        if (step_req) begin
          state_d       = StStep;
          pulsed_once_d = 1'b0;
        end else if (!run_sync_q) begin
          state_d = StIdle;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge RESETN) begin
    if (!RESETN) begin
      state_q       <= StIdle;
      cpu_ce_q      <= 1'b0;
      pulsed_once_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpu_ce_q      <= cpu_ce_d;
      pulsed_once_q <= pulsed_once_d;
    end
  end

  assign cpu_ce    = cpu_ce_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_exec_step_controller.sv
// Directed bench for exec_step_controller with a small control-unit model wrapping step_in 0..3.
module tb_exec_step_controller;
  localparam int unsigned PcW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           run_sw = 1'b0;
  logic           step_btn = 1'b0;
  logic           cpu_halted = 1'b0;
  logic           bp_en = 1'b0;
  logic [PcW-1:0] bp_pc = '0;
  logic [1:0]     step_in;
  logic [PcW-1:0] pc_in;
  logic           cpu_ce;
  logic [2:0]     state_out;

  int total = 0;
  int bad = 0;
  int ce_count = 0;
  int wide = 0;
  int cyc = 0;
  logic ce_prev = 1'b0;
  logic saw_break;

  always #5 clk = ~clk;

  exec_step_controller #(
    .DIV_WIDTH      (3),
    .DEBOUNCE_CYCLES(4),
    .PC_W           (PcW)
  ) dut (
    .CLK100MHZ (clk),
    .RESETN    (rst_n),
    .run_sw    (run_sw),
    .step_btn  (step_btn),
    .step_in   (step_in),
    .pc_in     (pc_in),
    .cpu_halted(cpu_halted),
    .bp_en     (bp_en),
    .bp_pc     (bp_pc),
    .cpu_ce    (cpu_ce),
    .state_out (state_out)
  );

  // Control-unit model: four micro-steps per instruction, pc advances on wrap.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_in <= 2'd0;
      pc_in   <= '0;
    end else if (cpu_ce) begin
      step_in <= step_in + 2'd1;
      if (step_in == 2'd3) pc_in <= pc_in + PcW'(1);
    end
  end

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ce_prev <= cpu_ce;
    if (cpu_ce) ce_count <= ce_count + 1;
    if (cpu_ce && ce_prev) wide <= wide + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) saw_break <= 1'b0;
    else if (state_out == 3'd3) saw_break <= 1'b1;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (state_out == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ce(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (cpu_ce) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (state_out !== 3'd0 || cpu_ce !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: state=%0d ce=%0b want state=0 ce=0", state_out, cpu_ce);
    end
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    total++;
    if (state_out !== 3'd0 || cpu_ce !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: state=%0d ce=%0b want state=0 ce=0", state_out, cpu_ce);
    end
  endtask

  task automatic test_run();
    bit ok;
    int c0, n0;
    run_sw = 1'b1;
    wait_state(3'd1, 10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL run_enter: state=%0d want 1", state_out);
    end
    wait_ce(20, ok);
    c0 = cyc;
    cycles(1);
    total++;
    if (!ok || cpu_ce !== 1'b0) begin
      bad++;
      $display("FAIL run_pulse_width: seen=%0b ce_next=%0b want seen=1 ce_next=0", ok, cpu_ce);
    end
    wait_ce(20, ok);
    total++;
    if (!ok || (cyc - c0) != 8) begin
      bad++;
      $display("FAIL run_period: seen=%0b period=%0d want 8", ok, cyc - c0);
    end
    n0 = ce_count;
    cycles(32);
    total++;
    if (ce_count - n0 != 4) begin
      bad++;
      $display("FAIL run_rate: pulses=%0d want 4 in 32 cycles", ce_count - n0);
    end
  endtask

  task automatic test_drain();
    bit ok;
    int n0;
    wait_ce(20, ok);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (step_in == 2'd2) break;
    end
    total++;
    if (!ok || step_in !== 2'd2) begin
      bad++;
      $display("FAIL drain_setup: step_in=%0d want 2", step_in);
    end
    run_sw = 1'b0;
    n0 = ce_count;
    cycles(40);
    total++;
    if (ce_count - n0 != 2 || state_out !== 3'd0 || step_in !== 2'd0) begin
      bad++;
      $display("FAIL drain: pulses=%0d state=%0d step_in=%0d want 2 0 0",
               ce_count - n0, state_out, step_in);
    end
    n0 = ce_count;
    cycles(24);
    total++;
    if (ce_count - n0 != 0) begin
      bad++;
      $display("FAIL idle_quiet: pulses=%0d want 0", ce_count - n0);
    end
  endtask

  task automatic test_step();
    bit ok;
    int n0;
    n0 = ce_count;
    step_btn = 1'b1;
    wait_state(3'd2, 20, ok);
    step_btn = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL step_enter: state=%0d want 2", state_out);
    end
    wait_state(3'd0, 80, ok);
    total++;
    if (!ok || ce_count - n0 != 4 || step_in !== 2'd0) begin
      bad++;
      $display("FAIL step_one_instr: idle=%0b pulses=%0d step_in=%0d want 1 4 0",
               ok, ce_count - n0, step_in);
    end
    n0 = ce_count;
    step_btn = 1'b1;
    cycles(3);
    step_btn = 1'b0;
    cycles(40);
    total++;
    if (ce_count - n0 != 0 || state_out !== 3'd0) begin
      bad++;
      $display("FAIL bounce: pulses=%0d state=%0d want 0 0", ce_count - n0, state_out);
    end
  endtask

  task automatic test_breakpoint();
    bit ok;
    int n0;
    do_reset();
    bp_en  = 1'b1;
    bp_pc  = PcW'(5);
    run_sw = 1'b1;
`ifdef BREAKPOINT_EN
    wait_state(3'd3, 300, ok);
    total++;
    if (!ok || pc_in !== PcW'(5) || step_in !== 2'd0) begin
      bad++;
      $display("FAIL bp_hit: reached=%0b pc=%0d step_in=%0d want 1 5 0", ok, pc_in, step_in);
    end
    n0 = ce_count;
    cycles(20);
    total++;
    if (ce_count - n0 != 0 || state_out !== 3'd3) begin
      bad++;
      $display("FAIL bp_hold: pulses=%0d state=%0d want 0 3", ce_count - n0, state_out);
    end
    n0 = ce_count;
    step_btn = 1'b1;
    wait_state(3'd2, 20, ok);
    step_btn = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_step_enter: state=%0d want 2", state_out);
    end
    wait_state(3'd1, 80, ok);
    total++;
    if (!ok || ce_count - n0 != 4 || pc_in !== PcW'(6)) begin
      bad++;
      $display("FAIL bp_resume: run=%0b pulses=%0d pc=%0d want 1 4 6", ok, ce_count - n0, pc_in);
    end
`else
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pc_in == PcW'(7)) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok || saw_break !== 1'b0 || state_out !== 3'd1) begin
      bad++;
      $display("FAIL bp_ignored: reached=%0b saw_break=%0b state=%0d want 1 0 1",
               ok, saw_break, state_out);
    end
    n0 = ce_count;
    cycles(16);
    total++;
    if (ce_count - n0 != 2) begin
      bad++;
      $display("FAIL bp_ignored_rate: pulses=%0d want 2", ce_count - n0);
    end
`endif
  endtask

  task automatic test_halted();
    bit ok;
    int n0;
    cpu_halted = 1'b1;
    wait_state(3'd4, 20, ok);
    cpu_halted = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL halt_enter: state=%0d want 4", state_out);
    end
    n0 = ce_count;
    run_sw = 1'b0;
    cycles(30);
    step_btn = 1'b1;
    cycles(10);
    step_btn = 1'b0;
    cycles(30);
    run_sw = 1'b1;
    cycles(20);
    total++;
    if (state_out !== 3'd4 || ce_count - n0 != 0) begin
      bad++;
      $display("FAIL halt_sticky: state=%0d pulses=%0d want 4 0", state_out, ce_count - n0);
    end
  endtask

  task automatic test_reset_mid_step();
    bit ok;
    run_sw = 1'b0;
    do_reset();
    cycles(2);
    total++;
    if (state_out !== 3'd0) begin
      bad++;
      $display("FAIL reset_from_halt: state=%0d want 0", state_out);
    end
    step_btn = 1'b1;
    wait_ce(60, ok);
    total++;
    if (!ok || state_out !== 3'd2) begin
      bad++;
      $display("FAIL mid_step_setup: ce_seen=%0b state=%0d want 1 2", ok, state_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (cpu_ce !== 1'b0 || state_out !== 3'd0) begin
      bad++;
      $display("FAIL async_reset: ce=%0b state=%0d want 0 0", cpu_ce, state_out);
    end
    step_btn = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(30);
    total++;
    if (state_out !== 3'd0 || wide != 0) begin
      bad++;
      $display("FAIL post_reset_idle: state=%0d wide_pulses=%0d want 0 0", state_out, wide);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_drain();
    test_step();
    test_breakpoint();
    test_halted();
    test_reset_mid_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
